// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid slave.
interface nios_system_sysid_checker_if;
  logic        address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address,
    output read,
    input  readdata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    output readdata,
    output waitrequest
  );
endinterface

// File: rtl/nios_system_sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (build timestamp) on a start pulse, compares both
// against the expected image values and holds the verdict until the next accepted start.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1459559916,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  nios_system_sysid_checker_if.master         avm,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                id_ok,
  output logic                                ts_ok,
  output logic                                timeout,
  output logic [31:0]                         id_value,
  output logic [31:0]                         ts_value
);

  typedef enum logic [1:0] {StIdle, StRdId, StRdTs, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  logic accept;
  logic expire;

  // read_q is high throughout RD_ID/RD_TS, so acceptance is just a dropped waitrequest.
  // Acceptance wins over expiry when both land in the same cycle.
  assign accept = read_q & ~avm.waitrequest;
  assign expire = read_q & avm.waitrequest & (cnt_q == (TIMEOUT_CYCLES - 16'd1));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRdId;
      StRdId: begin
        if (accept)      state_d = StRdTs;
        else if (expire) state_d = StDone;
      end
      StRdTs: if (accept || expire) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the bus strobes, counter and result registers.
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    read_d    = read_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    id_ok_d   = id_ok_q;
    ts_ok_d   = ts_ok_q;
    timeout_d = timeout_q;
    id_d      = id_q;
    ts_d      = ts_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          done_d = 1'b1;
          pass_d = id_ok_q & ts_ok_q & ~timeout_q;
        end
        if (start) begin
          cnt_d     = '0;
          addr_d    = 1'b0;
          read_d    = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          id_d      = '0;
          ts_d      = '0;
        end
      end
      StRdId, StRdTs: begin
        if (accept) begin
          cnt_d = '0;
          if (state_q == StRdId) begin
            id_d    = avm.readdata;
            id_ok_d = (avm.readdata == EXPECTED_ID);
            addr_d  = 1'b1;
          end else begin
            ts_d    = avm.readdata;
            ts_ok_d = (avm.readdata == EXPECTED_TIMESTAMP);
            addr_d  = 1'b0;
            read_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end else if (expire) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          addr_d    = 1'b0;
          read_d    = 1'b0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        read_d = 1'b0;
        addr_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
    end
  end

  assign avm.address = addr_q;
  assign avm.read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
